// File: rtl/step_monitor.sv
// ---------------------------------------------------------------------------
// step_monitor
//
// Receive-side decoder for the floppy step/dir/sel interface. Watches the
// drive pins and rebuilds the head position, the number of accepted steps and
// the period between the last two steps. The period is counted in the same
// 22-bit clock units as the floppy pitch setpoint, so reg_ctrl can read it
// back for loopback checks and closed-loop pitch checks.
//
// Optional build macro: STEP_MONITOR_GLITCH_FILTER_EN
//   Defined   : a step only counts once the synchronised step line has been
//               low for MIN_PULSE clocks while the drive is selected.
//               Pin-to-output latency is 4 + MIN_PULSE clocks.
//   Undefined : a step counts on the bare falling edge, and MIN_PULSE has no
//               effect. Pin-to-output latency is 4 clocks.
//
// Ports
//   clk          in   1   system clock, 50 MHz
//   rst          in   1   synchronous, active-high reset
//   step_in      in   1   drive step line, active-low pulse, asynchronous
//   dir_in       in   1   direction, 1 = inward (track+1), asynchronous
//   sel_in       in   1   drive select, active-low, asynchronous
//   clear        in   1   single-cycle request to zero position/count/flags
//   track        out  7   head position, 0..MAX_TRACK
//   step_count   out  16  accepted step events, wraps modulo 2^16
//   period       out  22  clocks between the last two accepted steps
//   period_valid out  1   period holds a fresh measurement
//   new_period   out  1   one-cycle pulse when period updates
//   at_track0    out  1   track == 0
//   overtravel   out  1   sticky: a step was attempted beyond 0 or MAX_TRACK
// ---------------------------------------------------------------------------
module step_monitor #(
    parameter int MAX_TRACK = 79,
    parameter int TIMEOUT   = 4194303,
    parameter int MIN_PULSE = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        sel_in,
    input  logic        clear,
    output logic [6:0]  track,
    output logic [15:0] step_count,
    output logic [21:0] period,
    output logic        period_valid,
    output logic        new_period,
    output logic        at_track0,
    output logic        overtravel
);

    if (MAX_TRACK < 1 || MAX_TRACK > 127 || TIMEOUT < 1 || TIMEOUT > 4194303 ||
        MIN_PULSE < 1) begin : g_param_check
        $error("step_monitor: parameter out of range");
    end

    localparam logic [6:0]  MAX_TRACK_V = 7'(MAX_TRACK);
    localparam logic [21:0] TIMEOUT_V   = 22'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers, bit order {sel, dir, step}
    // -----------------------------------------------------------------------
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       step_prev_q;
    logic [1:0] sync_ok_q;   // shifts in ones; bit 1 set once sync2_q holds pin data
    logic       primed_q;    // a genuine high has been seen on the step line
    logic       step_s;
    logic       dir_s;
    logic       sel_s;
    logic       fall;

    assign step_s = sync2_q[0];
    assign dir_s  = sync2_q[1];
    assign sel_s  = sync2_q[2];

    // NOTE: every register below updates with <= so all flops sample the values
    // from before the edge; blocking assignments here would collapse the
    // two-flop synchroniser into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            step_prev_q <= 1'b1;
            sync_ok_q   <= '0;
            primed_q    <= 1'b0;
        end else begin
            sync1_q     <= {sel_in, dir_in, step_in};
            sync2_q     <= sync1_q;
            step_prev_q <= step_s;
            sync_ok_q   <= {sync_ok_q[0], 1'b1};
            primed_q    <= primed_q | (sync_ok_q[1] & step_s);
        end
    end

    // The reset value of 1 in the synchroniser is not a real observation of the
    // pin, so a step held low across reset must not look like a falling edge.
    assign fall = primed_q & step_prev_q & ~step_s;

    // -----------------------------------------------------------------------
    // Event qualification
    // -----------------------------------------------------------------------
    logic event_d;
    logic event_q;
    logic dir_ev_q;

`ifdef STEP_MONITOR_GLITCH_FILTER_EN
    localparam int LW = $clog2(MIN_PULSE + 1);
    localparam logic [LW-1:0] MIN_PULSE_V = LW'(MIN_PULSE);

    logic          armed_q;
    logic          armed_d;
    logic [LW-1:0] low_cnt_q;
    logic [LW-1:0] low_cnt_d;

    // A falling edge arms the low-width counter; a rise or a deselect aborts
    // it, and the event fires once, when the counter reaches MIN_PULSE.
    // NOTE: each variable gets its default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        event_d   = 1'b0;
        armed_d   = armed_q;
        low_cnt_d = low_cnt_q;
        if (fall && !sel_s) begin
            armed_d   = 1'b1;
            low_cnt_d = LW'(1);
        end else if (armed_q) begin
            if (step_s || sel_s) begin
                armed_d = 1'b0;
            end else if (low_cnt_q == MIN_PULSE_V) begin
                event_d = 1'b1;
                armed_d = 1'b0;
            end else begin
                low_cnt_d = low_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            low_cnt_q <= '0;
        end else begin
            armed_q   <= armed_d;
            low_cnt_q <= low_cnt_d;
        end
    end
`else
    assign event_d = fall & ~sel_s;
`endif

    // Registering the event gives the fixed 4-clock pin-to-output latency;
    // dir is captured alongside it from the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_q  <= 1'b0;
            dir_ev_q <= 1'b0;
        end else begin
            event_q  <= event_d;
            dir_ev_q <= dir_s;
        end
    end

    // -----------------------------------------------------------------------
    // Position, step count and period FSM
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [21:0] cnt_q, cnt_d;
    logic [21:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        new_period_q, new_period_d;
    logic [6:0]  track_q, track_d;
    logic [15:0] count_q, count_d;
    logic        over_q, over_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        valid_d      = valid_q;
        new_period_d = 1'b0;
        track_d      = track_q;
        count_d      = count_q;
        over_d       = over_q;

        if (clear) begin
            // clear wins over a coincident event, which is simply dropped
            track_d = '0;
            count_d = '0;
            over_d  = 1'b0;
            valid_d = 1'b0;
            state_d = S_IDLE;
        end else begin
            if (event_q) begin
                count_d = count_q + 16'd1;
                if (dir_ev_q) begin
                    if (track_q == MAX_TRACK_V) over_d = 1'b1;
                    else                        track_d = track_q + 7'd1;
                end else begin
                    if (track_q == 7'd0) over_d = 1'b1;
                    else                 track_d = track_q - 7'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    // first event after reset, clear or timeout only arms
                    if (event_q) begin
                        cnt_d   = 22'd1;
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (event_q) begin
                        period_d     = cnt_q;
                        valid_d      = 1'b1;
                        new_period_d = 1'b1;
                        cnt_d        = 22'd1;
                    end else if (cnt_q >= TIMEOUT_V) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 22'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            new_period_q <= 1'b0;
            track_q      <= '0;
            count_q      <= '0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            new_period_q <= new_period_d;
            track_q      <= track_d;
            count_q      <= count_d;
            over_q       <= over_d;
        end
    end

    assign track        = track_q;
    assign step_count   = count_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign new_period   = new_period_q;
    assign overtravel   = over_q;
    assign at_track0    = (track_q == 7'd0);

endmodule
